// File: rtl/stdout_tx_ctrl.sv
// Buffers core stdout bytes in a FIFO and feeds uart_tx one byte at a time, stalling the core when full.
// Optional STDOUT_TX_CRLF_EN: expand each LF (0x0A) into CR LF on the wire.
module stdout_tx_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    stdout,
  input  logic          stdout_en,
  output logic          cpu_hold,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_ready,
  output logic [AW:0]   fifo_level,
  output logic          overflow
);

  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  state_t      state;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] level_next;
  logic [7:0]  head;
  logic        stdout_en_d;
  logic        push;
  logic        accept;
  logic        pop;
  logic        send_ok;
  logic        full;
  logic        empty;
`ifdef STDOUT_TX_CRLF_EN
  logic        cr_sent;
  logic        send_cr;
`endif

  assign fifo_level = wptr - rptr;
  assign full       = (fifo_level == LW'(DEPTH));
  assign empty      = (fifo_level == '0);
  assign head       = mem[rptr[AW-1:0]];
  assign push       = stdout_en & ~stdout_en_d;
  assign send_ok    = (state == IDLE) & ~empty & tx_ready;

  // The CR for a head LF goes out first without popping; cr_sent marks that head entry as done.
`ifdef STDOUT_TX_CRLF_EN
  assign send_cr    = (head == 8'h0A) & ~cr_sent;
  assign pop        = send_ok & ~send_cr;
`else
  assign pop        = send_ok;
`endif

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign accept     = push & (~full | pop);
  assign level_next = fifo_level + LW'(accept) - LW'(pop);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr[AW-1:0]] <= stdout;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      wptr        <= '0;
      rptr        <= '0;
      stdout_en_d <= 1'b0;
      cpu_hold    <= 1'b0;
      overflow    <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
`ifdef STDOUT_TX_CRLF_EN
      cr_sent     <= 1'b0;
`endif
    end else begin
      stdout_en_d <= stdout_en;
      cpu_hold    <= (level_next == LW'(DEPTH));
      if (accept) begin
        wptr <= wptr + LW'(1);
      end
      if (pop) begin
        rptr <= rptr + LW'(1);
      end
      if (push && !accept) begin
        overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (send_ok) begin
            tx_start <= 1'b1;
            state    <= START;
`ifdef STDOUT_TX_CRLF_EN
            if (send_cr) begin
              tx_data <= 8'h0D;
              cr_sent <= 1'b1;
            end else begin
              tx_data <= head;
              cr_sent <= 1'b0;
            end
`else
            tx_data  <= head;
`endif
          end
        end
        START: begin
          if (!tx_ready) begin
            tx_start <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (tx_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stdout_tx_ctrl.sv
// Scoreboard bench for stdout_tx_ctrl: a uart_tx model pops expected bytes as each one is accepted.
// Honours STDOUT_TX_CRLF_EN by expanding expected LF bytes into CR LF.
module tb_stdout_tx_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    stdout;
  logic          stdout_en;
  logic          cpu_hold;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_ready;
  logic [AW:0]   fifo_level;
  logic          overflow;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         stall = 1'b0;
  int         busy = 0;

  always #5 clk = ~clk;

  stdout_tx_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .stdout     (stdout),
    .stdout_en  (stdout_en),
    .cpu_hold   (cpu_hold),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_ready   (tx_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] b);
`ifdef STDOUT_TX_CRLF_EN
    if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(b);
  endtask

  // One stdout_en pulse: high for one clock, then low for one clock.
  task automatic apply_stimulus(input logic [7:0] b);
    @(negedge clk);
    stdout    = b;
    stdout_en = 1'b1;
    @(negedge clk);
    stdout_en = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || fifo_level != 0 || tx_start || !tx_ready || busy != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_in_time", 32'(n < 3000), 32'd1);
    repeat (5) @(negedge clk);
  endtask

  // uart_tx model and monitor: accepts a byte when tx_start is seen with ready high.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        tx_ready = 1'b1;
        busy     = 0;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) tx_ready = !stall;
      end else if (stall) begin
        tx_ready = 1'b0;
      end else if (tx_start && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_byte: got %02h expected none", tx_data);
        end else begin
          check_output("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        busy     = 6;
        tx_ready = 1'b0;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rstn      = 1'b0;
    stdout    = 8'h00;
    stdout_en = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_tx_start", 32'(tx_start), 32'd0);
    check_output("rst_tx_data", 32'(tx_data), 32'd0);
    check_output("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("rst_level", 32'(fifo_level), 32'd0);
    check_output("rst_overflow", 32'(overflow), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: level 1 one clock after the edge, tx_start two clocks after.
    @(negedge clk);
    stdout    = 8'h41;
    stdout_en = 1'b1;
    expect_byte(8'h41);
    @(negedge clk);
    stdout_en = 1'b0;
    check_output("lat_level1", 32'(fifo_level), 32'd1);
    check_output("lat_start_low", 32'(tx_start), 32'd0);
    @(negedge clk);
    check_output("lat_start_high", 32'(tx_start), 32'd1);
    check_output("lat_tx_data", 32'(tx_data), 32'h41);
    check_output("lat_level0", 32'(fifo_level), 32'd0);
    wait_drain();

    // Held strobe yields exactly one byte.
    @(negedge clk);
    stdout    = 8'h42;
    stdout_en = 1'b1;
    expect_byte(8'h42);
    repeat (20) @(negedge clk);
    stdout_en = 1'b0;
    wait_drain();

    // Fill with the transmitter stalled, then overflow.
    @(posedge clk);
    #1 stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(8'(i));
      expect_byte(8'(i));
      if (i == 14) begin
        check_output("fill15_level", 32'(fifo_level), 32'd15);
        check_output("fill15_hold", 32'(cpu_hold), 32'd0);
      end
    end
    check_output("full_hold", 32'(cpu_hold), 32'd1);
    check_output("full_level", 32'(fifo_level), 32'd16);
    check_output("full_no_ovf", 32'(overflow), 32'd0);
    apply_stimulus(8'hEE);
    check_output("ovf_set", 32'(overflow), 32'd1);
    check_output("ovf_level", 32'(fifo_level), 32'd16);
    @(posedge clk);
    #1 stall = 1'b0;
    n = 0;
    while (fifo_level != 15 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("first_pop_seen", 32'(n < 50), 32'd1);
    check_output("hold_cleared", 32'(cpu_hold), 32'd0);
    wait_drain();
    check_output("ovf_sticky", 32'(overflow), 32'd1);

    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_output("ovf_cleared", 32'(overflow), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Full FIFO with push and pop in the same clock.
    @(posedge clk);
    #1 stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(8'(8'h20 + i));
      expect_byte(8'(8'h20 + i));
    end
    check_output("pp_full_level", 32'(fifo_level), 32'd16);
    @(posedge clk);
    #1 stall = 1'b0;
    @(negedge clk);
    stdout    = 8'h30;
    stdout_en = 1'b1;
    expect_byte(8'h30);
    @(negedge clk);
    stdout_en = 1'b0;
    check_output("pp_level", 32'(fifo_level), 32'd16);
    check_output("pp_no_ovf", 32'(overflow), 32'd0);
    check_output("pp_hold", 32'(cpu_hold), 32'd1);
    check_output("pp_start", 32'(tx_start), 32'd1);
    wait_drain();

    // Reset while the first byte is in flight and three more are queued.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(8'(8'h50 + i));
      expect_byte(8'(8'h50 + i));
    end
    check_output("busy_level", 32'(fifo_level), 32'd3);
    check_output("busy_start", 32'(tx_start), 32'd0);
    #1 rstn = 1'b0;
    exp_q.delete();
    #1;
    check_output("abort_start", 32'(tx_start), 32'd0);
    check_output("abort_level", 32'(fifo_level), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    check_output("after_abort_level", 32'(fifo_level), 32'd0);

    // LF handling, including adjacent LFs.
    apply_stimulus(8'h0A);
    expect_byte(8'h0A);
    wait_drain();
    apply_stimulus(8'h41);
    expect_byte(8'h41);
    apply_stimulus(8'h0A);
    expect_byte(8'h0A);
    apply_stimulus(8'h0A);
    expect_byte(8'h0A);
    wait_drain();

    check_output("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stdout_tx_ctrl.md
Name: stdout_tx_ctrl

Overview:
Sits between the Brainfuck core's stdout/stdout_en interface and the uart_tx transmitter, replacing the ad-hoc start/ready logic at top level. It captures each output byte into a FIFO and sequences the UART start/ready handshake one byte at a time. It raises cpu_hold to stall the core's clock when the buffer cannot accept another byte. Single clock domain: the uart clk; stdout/stdout_en arrive already synchronised to clk.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
AW, 4, log2(DEPTH); pointer width.

Ports:
clk  input  1  system clock, same clock as uart_tx.
rstn  input  1  asynchronous active-low reset.
stdout  input  8  output byte from core; valid while stdout_en is high.
stdout_en  input  1  level strobe from core; one byte per 0->1 edge.
cpu_hold  output  1  high when FIFO full; top level gates cpu_clk with it.
tx_data  output  8  byte presented to uart_tx.data.
tx_start  output  1  to uart_tx.start.
tx_ready  input  1  from uart_tx.ready; low while transmitting.
fifo_level  output  AW+1  current FIFO occupancy, 0..DEPTH.
overflow  output  1  sticky; set when a byte is dropped.

Behaviour:
- Reset (rstn low, asynchronous): pointers and level 0, FSM IDLE, tx_start 0, tx_data 0x00, cpu_hold 0, overflow 0, edge-detect register 0. Reset mid-transmission aborts the byte: tx_start drops immediately and FIFO contents are discarded.
- Capture: registered stdout_en_d. Push when stdout_en & !stdout_en_d. stdout is sampled in the same cycle. Holding stdout_en high does not push again.
- Push when full: the byte is dropped, overflow is set and stays set until reset. Exception: a pop in the same cycle frees a slot and the push is accepted.
- Pointers wrap modulo DEPTH. fifo_level = wptr - rptr, computed with an extra pointer bit.
- cpu_hold = (fifo_level == DEPTH), registered from next-state level, so it asserts in the cycle after the filling push.
- FSM states:
  - IDLE: if FIFO non-empty and tx_ready high, pop, load tx_data from the head, set tx_start, go to START.
  - START: hold tx_start high until tx_ready is sampled low, then clear tx_start and go to BUSY.
  - BUSY: wait for tx_ready high, then go to IDLE.
- Latency: push edge at cycle N writes the FIFO at the clock ending N. IDLE pops at N+1. tx_start is high from N+2.
- Back-to-back bytes: the next pop happens in the IDLE cycle after BUSY exits. The minimum gap is one clock between tx_ready rising and the next tx_start.
- tx_data is stable from tx_start rise until the next pop.
- Empty FIFO: the FSM stays in IDLE and tx_start stays 0.

Optional Feature:
STDOUT_TX_CRLF_EN:
- Defined: when the head byte is 0x0A, IDLE first sends 0x0D without popping, through the full START/BUSY cycle. It then sends 0x0A and pops. A per-entry flag prevents a second CR for the same byte.
- Undefined: bytes are sent unmodified and the flag logic is absent.

Test Plan:
- Reset, then one stdout_en pulse with stdout=0x41 -> tx_start rises 2 clocks after the edge with tx_data=0x41; fifo_level goes 1 then 0; one START/BUSY cycle.
- stdout_en held high 20 clocks with stdout=0x42 -> exactly one byte 0x42 transmitted.
- With tx_ready held low, push 16 bytes 0x00..0x0F -> cpu_hold=1, fifo_level=16. A 17th edge sets overflow=1 and the byte is dropped. Release tx_ready -> bytes 0x00..0x0F are sent in order and cpu_hold clears after the first pop.
- Full FIFO with push and pop in the same cycle -> byte accepted, level stays 16, overflow stays 0.
- Assert rstn low during BUSY with 3 bytes queued -> tx_start=0, fifo_level=0 immediately. No further bytes after release.
- With STDOUT_TX_CRLF_EN, push 0x0A -> transmitted sequence is 0x0D then 0x0A. Without the macro, only 0x0A is sent.
